// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: owns the PC, reads the combinational ROM and queues {pc, inst} for decode.
// Optional macro FETCH_ALIGN_CHK_EN: misaligned redirect targets halt fetch and raise fetch_adel_o.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_inst,
   input  logic        br_flag_i,
   input  logic [31:0] br_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        fetch_adel_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t         state, state_d;
   logic [31:0]    pc, pc_d;
   logic [AW-1:0]  head, head_d, tail, tail_d;
   logic [CW-1:0]  count, count_d;
   logic [31:0]    buf_pc   [DEPTH];
   logic [31:0]    buf_inst [DEPTH];
   logic           rom_ce_d, adel_d, id_valid_d;
   logic [31:0]    id_pc_d, id_inst_d;
   logic           br_take, redirect, misalign, push, pop;
   logic [31:0]    tgt, tgt_pc;

   assign rom_addr = pc;

   // Redirect arbitration (flush beats branch; branches ignored while halted) and handshake terms.
   always_comb begin
      br_take  = br_flag_i && !flush_i && (state != S_HALT);
      redirect = flush_i || br_take;
      tgt      = flush_i ? new_pc_i : br_target_i;
`ifdef FETCH_ALIGN_CHK_EN
      misalign = redirect && (tgt[1:0] != 2'b00);
      tgt_pc   = tgt;
`else
      misalign = 1'b0;
      tgt_pc   = tgt & ~32'h0000_0003;
`endif
      pop  = id_valid_o && id_ready_i;
      push = rom_ce && !redirect && ((count < CW'(DEPTH)) || pop);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_RESET;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_RESET: state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
      if (redirect) state_d = misalign ? S_HALT : S_RUN;
   end

   // Next values for PC, buffer pointers and the registered decode-side view.
   always_comb begin
      pc_d     = pc;
      head_d   = head;
      tail_d   = tail;
      count_d  = count;
      rom_ce_d = (state_d == S_RUN);
      adel_d   = fetch_adel_o;
      if (redirect) begin
         pc_d    = tgt_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         adel_d  = misalign;
      end else begin
         if (push) begin
            pc_d   = pc + 32'd4;
            tail_d = tail + AW'(1);
         end
         if (pop) head_d = head + AW'(1);
         if (push && !pop)      count_d = count + CW'(1);
         else if (pop && !push) count_d = count - CW'(1);
      end
      id_valid_d = (count_d != '0);
      id_pc_d    = id_pc_o;
      id_inst_d  = id_inst_o;
      if (id_valid_d) begin
         // The new head may be the word being written this very cycle.
         if (push && (tail == head_d)) begin
            id_pc_d   = pc;
            id_inst_d = rom_inst;
         end else begin
            id_pc_d   = buf_pc[head_d];
            id_inst_d = buf_inst[head_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         rom_ce       <= 1'b0;
         fetch_adel_o <= 1'b0;
         id_valid_o   <= 1'b0;
         id_pc_o      <= '0;
         id_inst_o    <= '0;
      end else begin
         pc           <= pc_d;
         head         <= head_d;
         tail         <= tail_d;
         count        <= count_d;
         rom_ce       <= rom_ce_d;
         fetch_adel_o <= adel_d;
         id_valid_o   <= id_valid_d;
         id_pc_o      <= id_pc_d;
         id_inst_o    <= id_inst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[tail]   <= pc;
         buf_inst[tail] <= rom_inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus hand sequences for halt and mid-run reset.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        br_flag_i;
   logic [31:0] br_target_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        fetch_adel_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ready;
      logic        br;
      logic [31:0] btgt;
      logic        fl;
      logic [31:0] fpc;
      logic        ce;
      logic [31:0] addr;
      logic        v;
      logic [31:0] idpc;
   } vec_t;

   vec_t tv[$];

   inst_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .rom_ce       (rom_ce),
      .rom_addr     (rom_addr),
      .rom_inst     (rom_inst),
      .br_flag_i    (br_flag_i),
      .br_target_i  (br_target_i),
      .flush_i      (flush_i),
      .new_pc_i     (new_pc_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o),
      .fetch_adel_o (fetch_adel_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   assign rom_inst = rom_word(rom_addr);

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   function automatic void add(input logic ready, input logic br, input logic [31:0] btgt,
                               input logic fl, input logic [31:0] fpc, input logic ce,
                               input logic [31:0] addr, input logic v, input logic [31:0] idpc);
      vec_t r;
      r.ready = ready; r.br = br; r.btgt = btgt; r.fl = fl; r.fpc = fpc;
      r.ce = ce; r.addr = addr; r.v = v; r.idpc = idpc;
      tv.push_back(r);
   endfunction

   task automatic drive(input logic ready, input logic br, input logic [31:0] btgt,
                        input logic fl, input logic [31:0] fpc);
      id_ready_i  = ready;
      br_flag_i   = br;
      br_target_i = btgt;
      flush_i     = fl;
      new_pc_i    = fpc;
   endtask

   task automatic chk_head(input string tag, input logic ce, input logic [31:0] addr,
                           input logic v, input logic [31:0] idpc);
      chk({tag, "_ce"}, 32'(rom_ce), 32'(ce));
      chk({tag, "_addr"}, rom_addr, addr);
      chk({tag, "_valid"}, 32'(id_valid_o), 32'(v));
      if (v) begin
         chk({tag, "_pc"}, id_pc_o, idpc);
         chk({tag, "_inst"}, id_inst_o, rom_word(idpc));
      end
   endtask

   initial begin
      // cycle-by-cycle: inputs for the cycle, expected outputs seen during it
      add(0, 0, 0,     0, 0,            0, 32'h0,        0, 0);
      add(0, 0, 0,     0, 0,            1, 32'h0,        0, 0);
      add(0, 0, 0,     0, 0,            1, 32'h4,        1, 32'h0);
      add(0, 0, 0,     0, 0,            1, 32'h8,        1, 32'h0);
      add(0, 0, 0,     0, 0,            1, 32'h8,        1, 32'h0);
      add(0, 0, 0,     0, 0,            1, 32'h8,        1, 32'h0);
      add(0, 0, 0,     0, 0,            1, 32'h8,        1, 32'h0);
      add(1, 0, 0,     0, 0,            1, 32'h8,        1, 32'h0);
      add(1, 0, 0,     0, 0,            1, 32'hC,        1, 32'h4);
      add(1, 1, 32'h40, 0, 0,           1, 32'h10,       1, 32'h8);
      add(1, 0, 0,     0, 0,            1, 32'h40,       0, 0);
      add(1, 0, 0,     0, 0,            1, 32'h44,       1, 32'h40);
      add(1, 1, 32'h40, 1, 32'h180,     1, 32'h48,       1, 32'h44);
      add(1, 0, 0,     0, 0,            1, 32'h180,      0, 0);
      add(1, 0, 0,     0, 0,            1, 32'h184,      1, 32'h180);
      add(1, 0, 0,     0, 0,            1, 32'h188,      1, 32'h184);
      add(1, 1, 32'h100, 0, 0,          1, 32'h18C,      1, 32'h188);
      add(1, 1, 32'h200, 0, 0,          1, 32'h100,      0, 0);
      add(1, 0, 0,     0, 0,            1, 32'h200,      0, 0);
      add(1, 0, 0,     0, 0,            1, 32'h204,      1, 32'h200);
      add(1, 0, 0,     1, 32'hFFFF_FFF8, 1, 32'h208,     1, 32'h204);
      add(1, 0, 0,     0, 0,            1, 32'hFFFF_FFF8, 0, 0);
      add(1, 0, 0,     0, 0,            1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
      add(1, 0, 0,     0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC);
      add(1, 0, 0,     0, 0,            1, 32'h4,        1, 32'h0);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_id_pc", id_pc_o, 32'h0);
      chk("rst_id_inst", id_inst_o, 32'h0);
      chk("rst_adel", 32'(fetch_adel_o), 32'h0);

      foreach (tv[i]) begin
         chk_head($sformatf("v%0d", i), tv[i].ce, tv[i].addr, tv[i].v, tv[i].idpc);
         chk($sformatf("v%0d_adel", i), 32'(fetch_adel_o), 32'h0);
         drive(tv[i].ready, tv[i].br, tv[i].btgt, tv[i].fl, tv[i].fpc);
         @(negedge clk);
      end

      // Misaligned branch target: halt in checked build, word-aligned fetch otherwise.
      chk_head("pre_mis", 1, 32'h8, 1, 32'h4);
      drive(1, 1, 32'h42, 0, 0);
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
`ifdef FETCH_ALIGN_CHK_EN
      for (int k = 0; k < 3; k++) begin
         chk_head($sformatf("halt%0d", k), 0, 32'h42, 0, 0);
         chk($sformatf("halt%0d_adel", k), 32'(fetch_adel_o), 32'h1);
         if (k == 1) drive(1, 1, 32'h80, 0, 0);
         else        drive(1, 0, 0, 0, 0);
         @(negedge clk);
      end
      drive(1, 0, 0, 1, 32'h180);
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
      chk_head("resume0", 1, 32'h180, 0, 0);
      chk("resume0_adel", 32'(fetch_adel_o), 32'h0);
      @(negedge clk);
      chk_head("resume1", 1, 32'h184, 1, 32'h180);
`else
      chk_head("mis0", 1, 32'h40, 0, 0);
      chk("mis0_adel", 32'(fetch_adel_o), 32'h0);
      @(negedge clk);
      chk_head("mis1", 1, 32'h44, 1, 32'h40);
`endif

      // Reset while the buffer is full: nothing survives.
      drive(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", 32'(id_valid_o), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 0, 0, 0);
      chk_head("mrst0", 0, 32'h0, 0, 0);
      chk("mrst0_id_pc", id_pc_o, 32'h0);
      chk("mrst0_id_inst", id_inst_o, 32'h0);
      chk("mrst0_adel", 32'(fetch_adel_o), 32'h0);
      @(negedge clk);
      chk_head("mrst1", 1, 32'h0, 0, 0);
      @(negedge clk);
      chk_head("mrst2", 1, 32'h4, 1, 32'h0);
      @(negedge clk);
      chk_head("mrst3", 1, 32'h8, 1, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
